cordic_stream_ctrl: RTL and testbench
=====================================

Name: cordic_stream_ctrl

Overview:
- Parametrised successor of the CORDIC I/O sequencer.
- Collects a two-word operand pair (X then Y) over a valid/ready input stream and latches a per-transaction mode (rotation or vectoring).
- Launches the CORDIC core with a one-cycle start pulse, waits for done with a timeout watchdog, then returns the two result words over a valid/ready output stream with a last marker.

Parameters:
- DATA_W, 13, width of operand and result words.
- TIMEOUT, 64, max cycles in WAIT before abort; must be >=2.
- CNT_W, 7, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  reset; synchronous, active-high.
- in_valid  in  1  input word valid.
- in_ready  out  1  ctrl accepts input word; a transfer occurs when in_valid & in_ready.
- in_data  in  DATA_W  operand word; first word is X, second is Y.
- in_mode  in  1  0=rotation, 1=vectoring; sampled with the X word only.
- cordic_start  out  1  one-cycle launch pulse to the core.
- cordic_mode  out  1  latched mode, stable from START until return to IDLE.
- cordic_x  out  DATA_W  latched X.
- cordic_y  out  DATA_W  latched Y.
- cordic_done  in  1  core finished; res_a and res_b valid in that cycle.
- res_a  in  DATA_W  first result (magnitude or x').
- res_b  in  DATA_W  second result (phase or y').
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts; a transfer occurs when out_valid & out_ready.
- out_data  out  DATA_W  result word.
- out_last  out  1  high with the second result word.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky abort flag.

Behaviour:
- Reset: all outputs 0; state IDLE; internal X, Y, A, B, mode and counter registers cleared. RESET overrides any in-flight transaction and any state, and takes effect at the next edge.
- States: IDLE, GET_Y, START, WAIT, OUT_A, OUT_B. All outputs are registered or decoded from state only; there is no combinational path from in_* to out_*.
- IDLE:
  - in_ready=1.
  - On an input transfer: capture X=in_data and mode=in_mode; clear timeout_err; go to GET_Y.
- GET_Y:
  - in_ready=1.
  - On an input transfer: capture Y; go to START.
  - Waits indefinitely for the Y word.
- START:
  - in_ready=0; cordic_start=1 for exactly this cycle; counter cleared; go to WAIT.
  - Latency: Y accepted at edge n gives cordic_start high in the cycle after edge n.
- WAIT:
  - in_ready=0.
  - If cordic_done=1: capture A=res_a and B=res_b; go to OUT_A.
  - Else, if counter == TIMEOUT-1: set timeout_err=1; go to IDLE with no output. Done takes priority over timeout in the same cycle.
  - Else: increment counter.
  - cordic_done outside WAIT is ignored.
- OUT_A:
  - out_valid=1, out_data=A, out_last=0.
  - Holds out_data stable while out_ready=0. On transfer, go to OUT_B.
- OUT_B:
  - out_valid=1, out_data=B, out_last=1.
  - On transfer, go to IDLE.
  - New input is accepted no earlier than the cycle after OUT_B completes; there is no overlap.
- Outside OUT_A/OUT_B: out_valid=0, out_last=0, out_data holds its last value.
- Width: words are passed through unmodified; no sign extension or arithmetic.
- in_mode on the Y word is ignored.

Test Plan:
- Basic rotation:
  - Stimulus: X=0x0100 (mode 0), Y=0x0000 back-to-back; core asserts done 5 cycles after start with res_a=0x00F0, res_b=0x0050; out_ready=1.
  - Required: cordic_start high exactly 1 cycle after Y accepted; out_data 0x00F0 then 0x0050 on consecutive cycles; out_last only on the second; busy falls the cycle after.
- Backpressure:
  - Stimulus: same as basic rotation, but out_ready=0 for 4 cycles in OUT_A, then toggle 1,0,1.
  - Required: out_data holds 0x00F0 for the full stall; exactly two transfers occur; no word is duplicated or dropped.
- Timeout:
  - Stimulus: TIMEOUT=8; core never asserts done.
  - Required: timeout_err=1 after 8 WAIT cycles; return to IDLE; out_valid never asserted; next X accepted clears timeout_err.
- Done/timeout collision:
  - Stimulus: cordic_done asserted on the final WAIT cycle.
  - Required: results are output normally; timeout_err stays 0.
- Mode and idle gaps:
  - Stimulus: X with in_mode=1, then 3 idle cycles, then Y with in_mode=0.
  - Required: cordic_mode=1 during START/WAIT; cordic_x/cordic_y match the inputs.
- Reset mid-operation:
  - Stimulus: assert RESET during WAIT, then during OUT_A with out_ready=0.
  - Required: next edge gives state IDLE, all outputs 0, in_ready=1; a following full transaction completes correctly.

Source files
------------

// File: rtl/cordic_stream_ctrl.sv
`default_nettype none
// ============================================================================
// cordic_stream_ctrl : streams an X/Y operand pair into a CORDIC core,
//                      watches for done with a watchdog, streams A/B back out
// Revision : 1.0
// ============================================================================
module cordic_stream_ctrl #(
  parameter int DATA_W  = 13,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  output logic              cordic_start,
  output logic              cordic_mode,
  output logic [DATA_W-1:0] cordic_x,
  output logic [DATA_W-1:0] cordic_y,
  input  logic              cordic_done,
  input  logic [DATA_W-1:0] res_a,
  input  logic [DATA_W-1:0] res_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              timeout_err
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GET_Y = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OUT_A = 3'd4,
    ST_OUT_B = 3'd5
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] b_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake and strobe outputs depend on the current state only.
  always_comb begin
    state_d      = state_q;
    in_ready     = 1'b0;
    cordic_start = 1'b0;
    out_valid    = 1'b0;
    out_last     = 1'b0;
    busy         = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = ST_GET_Y;
        end
      end
      ST_GET_Y: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = ST_START;
        end
      end
      ST_START: begin
        cordic_start = 1'b1;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        if (cordic_done) begin
          state_d = ST_OUT_A;
        end else if (cnt_q == LAST_CNT) begin
          state_d = ST_IDLE;
        end
      end
      ST_OUT_A: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_OUT_B;
        end
      end
      ST_OUT_B: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // out_data doubles as the A result register; it is reloaded with B once A
  // has been taken, and then simply holds until the next result arrives.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cordic_x    <= '0;
      cordic_y    <= '0;
      cordic_mode <= 1'b0;
      cnt_q       <= '0;
      b_q         <= '0;
      out_data    <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            cordic_x    <= in_data;
            cordic_mode <= in_mode;
            timeout_err <= 1'b0;
          end
        end
        ST_GET_Y: begin
          if (in_valid) begin
            cordic_y <= in_data;
          end
        end
        ST_START: begin
          cnt_q <= '0;
        end
        ST_WAIT: begin
          if (cordic_done) begin
            out_data <= res_a;
            b_q      <= res_b;
          end else if (cnt_q == LAST_CNT) begin
            timeout_err <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_OUT_A: begin
          if (out_ready) begin
            out_data <= b_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cordic_stream_ctrl.sv
`default_nettype none
// ============================================================================
// tb_cordic_stream_ctrl : directed + random transactions against a
//                         transaction-level expectation of the sequencer
// Revision : 1.0
// ============================================================================
module tb_cordic_stream_ctrl;

  localparam int DW = 13;
  localparam int TO = 8;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_mode = 1'b0;
  logic          cordic_start;
  logic          cordic_mode;
  logic [DW-1:0] cordic_x;
  logic [DW-1:0] cordic_y;
  logic          cordic_done = 1'b0;
  logic [DW-1:0] res_a = '0;
  logic [DW-1:0] res_b = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          timeout_err;

  int vectors = 0;
  int errors  = 0;

  cordic_stream_ctrl #(.DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET(RESET),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .cordic_start(cordic_start), .cordic_mode(cordic_mode),
    .cordic_x(cordic_x), .cordic_y(cordic_y),
    .cordic_done(cordic_done), .res_a(res_a), .res_b(res_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_reset_state();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_start", cordic_start, 0);
    chk("rst_mode", cordic_mode, 0);
    chk("rst_x", cordic_x, 0);
    chk("rst_y", cordic_y, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_timeout_err", timeout_err, 0);
  endtask

  // Deliver X (with mode), idle gap with stray done pulses, then Y; ends in
  // the first WAIT cycle.
  task automatic send_operands(input logic [DW-1:0] x, input logic m,
                               input int gap, input logic [DW-1:0] y);
    chk("idle_in_ready", in_ready, 1);
    in_valid = 1'b1; in_data = x; in_mode = m;
    tick();
    chk("gety_busy", busy, 1);
    chk("gety_in_ready", in_ready, 1);
    chk("gety_x", cordic_x, x);
    chk("gety_mode", cordic_mode, m);
    chk("x_clears_err", timeout_err, 0);
    in_valid = 1'b0; in_data = DW'($urandom);
    for (int g = 0; g < gap; g++) begin
      cordic_done = 1'b1; res_a = DW'($urandom); res_b = DW'($urandom);
      tick();
      chk("gap_no_start", cordic_start, 0);
      chk("gap_in_ready", in_ready, 1);
      chk("gap_no_valid", out_valid, 0);
    end
    cordic_done = 1'b0;
    in_valid = 1'b1; in_data = y; in_mode = ~m;
    tick();
    in_valid = 1'b0; in_mode = 1'b0; in_data = DW'($urandom);
    chk("start_pulse", cordic_start, 1);
    chk("start_in_ready", in_ready, 0);
    chk("start_x", cordic_x, x);
    chk("start_y", cordic_y, y);
    chk("start_mode", cordic_mode, m);
    tick();
  endtask

  // Core asserts done on WAIT cycle k (k outside 1..TO means never).
  // Results come back iff done arrives within TO cycles, in A,B order.
  task automatic wait_and_drain(input logic m, input int k,
                                input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [15:0] pat);
    logic          exp_to;
    logic [DW-1:0] q[$];
    exp_to = (k < 1 || k > TO);
    for (int i = 1; i <= TO; i++) begin
      chk("wait_start_low", cordic_start, 0);
      chk("wait_busy", busy, 1);
      chk("wait_no_valid", out_valid, 0);
      chk("wait_no_err", timeout_err, 0);
      chk("wait_mode", cordic_mode, m);
      chk("wait_in_ready", in_ready, 0);
      if (i == k) begin
        cordic_done = 1'b1; res_a = a; res_b = b;
      end
      tick();
      cordic_done = 1'b0; res_a = DW'($urandom); res_b = DW'($urandom);
      if (i == k) break;
    end
    chk("timeout_err", timeout_err, exp_to);
    chk("post_wait_busy", busy, !exp_to);
    chk("post_wait_valid", out_valid, !exp_to);
    if (!exp_to) begin
      q.push_back(a);
      q.push_back(b);
      for (int c = 0; c < 40 && q.size() > 0; c++) begin
        chk("out_valid", out_valid, 1);
        chk("out_data", out_data, q[0]);
        chk("out_last", out_last, (q.size() == 1));
        out_ready = (c < 16) ? pat[c] : 1'b1;
        tick();
        if (out_ready) void'(q.pop_front());
        out_ready = 1'b0;
      end
      chk("drain_complete", q.size(), 0);
      chk("out_data_hold", out_data, b);
    end
    chk("end_busy", busy, 0);
    chk("end_out_valid", out_valid, 0);
    chk("end_out_last", out_last, 0);
    chk("end_in_ready", in_ready, 1);
  endtask

  task automatic run_txn(input logic [DW-1:0] x, input logic m, input int gap,
                         input logic [DW-1:0] y, input int k,
                         input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [15:0] pat);
    send_operands(x, m, gap, y);
    wait_and_drain(m, k, a, b, pat);
  endtask

  initial begin
    tick();
    tick();
    chk_reset_state();
    RESET = 1'b0;
    tick();
    chk_reset_state();

    // basic rotation, then backpressure 0,0,0,0,1,0,1
    run_txn(13'h0100, 1'b0, 0, 13'h0000, 5, 13'h00F0, 13'h0050, 16'hFFFF);
    run_txn(13'h0100, 1'b0, 0, 13'h0000, 5, 13'h00F0, 13'h0050, 16'hFF50);
    // timeout, then done exactly on the last WAIT cycle
    run_txn(13'h0ABC, 1'b1, 0, 13'h1234, 0, 13'h0, 13'h0, 16'hFFFF);
    run_txn(13'h1FFF, 1'b0, 1, 13'h0001, TO, 13'h1555, 13'h0AAA, 16'hFFFF);
    // vectoring mode with idle gap; done on the first WAIT cycle
    run_txn(13'h0321, 1'b1, 3, 13'h1F00, 1, 13'h0042, 13'h1001, 16'h5555);

    // reset during WAIT
    send_operands(13'h0777, 1'b1, 0, 13'h0888);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk_reset_state();
    // reset during OUT_A with out_ready low
    send_operands(13'h0999, 1'b1, 1, 13'h0AAA);
    cordic_done = 1'b1; res_a = 13'h0BBB; res_b = 13'h0CCC;
    tick();
    cordic_done = 1'b0;
    chk("rst_pre_out_valid", out_valid, 1);
    chk("rst_pre_out_data", out_data, 13'h0BBB);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk_reset_state();
    run_txn(13'h0101, 1'b0, 2, 13'h0202, 3, 13'h0303, 13'h0404, 16'h00F0);

    for (int t = 0; t < 24; t++) begin
      run_txn(DW'($urandom), 1'($urandom), $urandom_range(0, 3), DW'($urandom),
              $urandom_range(1, TO + 2), DW'($urandom), DW'($urandom),
              16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
